// File: rtl/regfile_reader.sv
// Register-file driven streamer: reads a length word, streams that many data words
// to a ready/valid consumer, then writes a status word and clears the start bit.
module regfile_reader #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned ADDR_DEPTH  = 12,
    parameter int unsigned LEN_ADDR    = 1,
    parameter int unsigned STATUS_ADDR = 2,
    parameter int unsigned DATA_BASE   = 3
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  control_reg,
    output logic [ADDR_DEPTH-1:0] address,
    output logic                  en_read,
    output logic                  en_write,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] stream_data,
    output logic                  stream_valid,
    input  logic                  stream_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [3:0] {
        IDLE, RD_LEN, CAP_LEN, RD_DATA, CAP_DATA, STREAM, WR_STAT, CLR_CTRL, FINISH
    } state_t;

    localparam logic [ADDR_DEPTH:0] MAX_LEN = (ADDR_DEPTH+1)'(2**ADDR_DEPTH - DATA_BASE);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_DEPTH-1:0] r_len;
    logic [ADDR_DEPTH-1:0] r_idx;
    logic                  r_clamped;
    logic                  r_blocked;

    logic [ADDR_DEPTH-1:0] w_len_raw;
    logic                  w_over;
    logic [ADDR_DEPTH-1:0] w_len_cap;
    logic [ADDR_DEPTH:0]   w_idx_inc;
    logic                  w_accept;

    logic [ADDR_DEPTH-1:0] w_idx_nxt;
    logic [ADDR_DEPTH-1:0] w_len_nxt;
    logic                  w_clamped_nxt;
    logic [DATA_WIDTH-1:0] w_stream_data_nxt;
    logic [DATA_WIDTH-1:0] w_status;
    logic [ADDR_DEPTH-1:0] w_address_nxt;
    logic [DATA_WIDTH-1:0] w_wr_data_nxt;

    assign w_len_raw = rd_data[ADDR_DEPTH-1:0];
    assign w_over    = ({1'b0, w_len_raw} > MAX_LEN);
    assign w_len_cap = w_over ? MAX_LEN[ADDR_DEPTH-1:0] : w_len_raw;
    assign w_idx_inc = {1'b0, r_idx} + (ADDR_DEPTH+1)'(1);
    assign w_accept  = (r_state == STREAM) && stream_valid && stream_ready;

    // All outputs are registered from the upcoming state, so each strobe lines up
    // exactly with the cycle spent in the state that owns it.
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_len        <= '0;
            r_idx        <= '0;
            r_clamped    <= 1'b0;
            r_blocked    <= 1'b0;
            address      <= '0;
            en_read      <= 1'b0;
            en_write     <= 1'b0;
            wr_data      <= '0;
            stream_data  <= '0;
            stream_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_idx        <= w_idx_nxt;
            r_clamped    <= w_clamped_nxt;
            // A start bit still set from the finished transfer must not retrigger.
            if (r_state == CLR_CTRL)
                r_blocked <= 1'b1;
            else if (!control_reg)
                r_blocked <= 1'b0;
            address      <= w_address_nxt;
            en_read      <= (w_state_nxt == RD_LEN) || (w_state_nxt == RD_DATA);
            en_write     <= (w_state_nxt == WR_STAT) || (w_state_nxt == CLR_CTRL);
            wr_data      <= w_wr_data_nxt;
            stream_data  <= w_stream_data_nxt;
            stream_valid <= (w_state_nxt == STREAM);
            busy         <= (w_state_nxt != IDLE);
            done         <= (w_state_nxt == FINISH);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (control_reg && !r_blocked) w_state_nxt = RD_LEN;
            RD_LEN:   w_state_nxt = CAP_LEN;
            CAP_LEN:  w_state_nxt = (w_len_cap == '0) ? WR_STAT : RD_DATA;
            RD_DATA:  w_state_nxt = CAP_DATA;
            CAP_DATA: w_state_nxt = STREAM;
            STREAM:   if (w_accept) w_state_nxt = (w_idx_inc < {1'b0, r_len}) ? RD_DATA : WR_STAT;
            WR_STAT:  w_state_nxt = CLR_CTRL;
            CLR_CTRL: w_state_nxt = FINISH;
            FINISH:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt         = r_idx;
        w_len_nxt         = r_len;
        w_clamped_nxt     = r_clamped;
        w_stream_data_nxt = stream_data;
        case (r_state)
            IDLE: begin
                if (w_state_nxt == RD_LEN) begin
                    w_idx_nxt     = '0;
                    w_len_nxt     = '0;
                    w_clamped_nxt = 1'b0;
                end
            end
            CAP_LEN: begin
                w_len_nxt     = w_len_cap;
                w_clamped_nxt = w_over;
            end
            CAP_DATA: w_stream_data_nxt = rd_data;
            STREAM:   if (w_accept) w_idx_nxt = w_idx_inc[ADDR_DEPTH-1:0];
            default:  ;
        endcase

        w_status                 = '0;
        w_status[ADDR_DEPTH:0]   = {1'b0, w_idx_nxt};
        w_status[DATA_WIDTH-2]   = w_clamped_nxt;
        w_status[DATA_WIDTH-1]   = 1'b1;

        w_address_nxt = '0;
        w_wr_data_nxt = '0;
        case (w_state_nxt)
            RD_LEN:  w_address_nxt = ADDR_DEPTH'(LEN_ADDR);
            RD_DATA: w_address_nxt = ADDR_DEPTH'(DATA_BASE) + w_idx_nxt;
            WR_STAT: begin
                w_address_nxt = ADDR_DEPTH'(STATUS_ADDR);
                w_wr_data_nxt = w_status;
            end
            default: ;
        endcase
    end

endmodule
